// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the two-requester SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BYTE_W     = 8;

  // Response owner: which requester a pending SRAM response belongs to.
  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // One-deep response tracker: the SRAM answers exactly one cycle after a grant.
  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   wr;
  } resp_t;

  localparam resp_t RESP_IDLE = '{valid: 1'b0, owner: OWNER_INST, wr: 1'b0};

  // Byte-enable width for a given data width.
  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Request/response bundle between the instruction port, data port and the shared SRAM.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = sram_arbiter_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = sram_arbiter_pkg::DATA_W_DEF
);
  localparam int unsigned STRB_W = sram_arbiter_pkg::strb_w(DATA_W);

  // Instruction requester
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  // Data requester
  logic              data_req;
  logic              data_wr;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // Shared SRAM port
  logic              sram_en;
  logic [STRB_W-1:0] sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  // Arbiter side
  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  sram_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  // Requesters and SRAM side
  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output sram_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the requester not granted most recently wins a conflict.
module sram_arbiter_rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_inst_i,
  input  logic req_data_i,
  output logic gnt_inst_c_o,
  output logic gnt_data_c_o
);

  owner_e last_grant_q;
  owner_e last_grant_d;

  // Remember who was granted last; reset favours INST on the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= OWNER_DATA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Combinational grant; nothing is granted while reset is held.
  always_comb begin
    gnt_inst_c_o = 1'b0;
    gnt_data_c_o = 1'b0;
    last_grant_d = last_grant_q;
    if (!rst) begin
      case ({req_inst_i, req_data_i})
        2'b10:   gnt_inst_c_o = 1'b1;
        2'b01:   gnt_data_c_o = 1'b1;
        2'b11: begin
          if (last_grant_q == OWNER_DATA) begin
            gnt_inst_c_o = 1'b1;
          end else begin
            gnt_data_c_o = 1'b1;
          end
        end
        default: ;
      endcase
      if (gnt_inst_c_o) begin
        last_grant_d = OWNER_INST;
      end else if (gnt_data_c_o) begin
        last_grant_d = OWNER_DATA;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-cycle SRAM port between an instruction and a data requester.
// Accepts one request per cycle; every accepted request gets exactly one response
// one cycle later, steered back to its owner.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);

  localparam int unsigned STRB_W = strb_w(DATA_W);

  logic gnt_inst;
  logic gnt_data;
  logic gnt_any;

  resp_t resp_q;
  resp_t resp_d;

  logic              inst_resp;
  logic              data_resp;
  logic              req_any;
  logic [STRB_W-1:0] sram_we_c;
  logic [ADDR_W-1:0] sram_addr_c;

  sram_arbiter_rr_arb2 u_rr_arb2 (
    .clk          (clk),
    .rst          (reset),
    .req_inst_i   (bus.inst_req),
    .req_data_i   (bus.data_req),
    .gnt_inst_c_o (gnt_inst),
    .gnt_data_c_o (gnt_data)
  );

  assign gnt_any = gnt_inst | gnt_data;

  // Next response descriptor: owner and kind of this cycle's grant, if any.
  always_comb begin
    resp_d = RESP_IDLE;
    if (gnt_any) begin
      resp_d.valid = 1'b1;
      resp_d.owner = gnt_data ? OWNER_DATA : OWNER_INST;
      resp_d.wr    = gnt_data & bus.data_wr;
    end
  end

  // Response tracker; reset drops any in-flight response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q <= RESP_IDLE;
    end else begin
      resp_q <= resp_d;
    end
  end

  // SRAM request side: address and write enables follow the winner.
  always_comb begin
    req_any     = (bus.inst_req | bus.data_req) & ~reset;
    sram_we_c   = '0;
    sram_addr_c = bus.inst_addr;
    if (gnt_data) begin
      sram_addr_c = bus.data_addr;
      if (bus.data_wr) begin
        sram_we_c = bus.data_wstrb;
      end
    end
  end

  // Response decode from the registered tracker.
  always_comb begin
    inst_resp = resp_q.valid & (resp_q.owner == OWNER_INST);
    data_resp = resp_q.valid & (resp_q.owner == OWNER_DATA);
  end

  assign bus.inst_addr_ok = gnt_inst;
  assign bus.data_addr_ok = gnt_data;

  assign bus.sram_en    = req_any;
  assign bus.sram_we    = sram_we_c;
  assign bus.sram_addr  = sram_addr_c;
  assign bus.sram_wdata = bus.data_wdata;

  assign bus.inst_data_ok = inst_resp;
  assign bus.data_data_ok = data_resp;
  assign bus.inst_rdata   = inst_resp ? bus.sram_rdata : '0;
  assign bus.data_rdata   = (data_resp & ~resp_q.wr) ? bus.sram_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised scoreboard bench for sram_arbiter with a small word-addressed SRAM model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned MEM_N = 16;

  typedef struct {
    int unsigned   due;
    bit            is_data;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    bit            v;
    logic [AW-1:0] addr;
  } ireq_t;

  typedef struct {
    bit            v;
    bit            wr;
    logic [SW-1:0] strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dreq_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc   = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  exp_t          sb[$];
  ireq_t         ip;
  dreq_t         dp;
  bit            last_data;
  logic [DW-1:0] ref_mem  [MEM_N];
  logic [DW-1:0] sram_mem [MEM_N];
  logic [DW-1:0] sram_rdata_q;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 0) return 32'h0280_0C0C;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // Synchronous SRAM: read data appears one cycle after an enabled read.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_N; i++) sram_mem[i] <= init_word(i);
      sram_rdata_q <= '0;
    end else if (bus.sram_en) begin
      if (bus.sram_we == '0) begin
        sram_rdata_q <= sram_mem[bus.sram_addr[5:2]];
      end else begin
        for (int b = 0; b < SW; b++)
          if (bus.sram_we[b]) sram_mem[bus.sram_addr[5:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end
    end
  end

  assign bus.sram_rdata = sram_rdata_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply();
    bus.inst_req   = ip.v;
    bus.inst_addr  = ip.addr;
    bus.data_req   = dp.v;
    bus.data_wr    = dp.wr;
    bus.data_wstrb = dp.strb;
    bus.data_addr  = dp.addr;
    bus.data_wdata = dp.wdata;
  endtask

  // Reference model: decide the winner from the arbitration rule, check the
  // request side, and queue the response due next cycle.
  task automatic evaluate();
    bit   gi;
    bit   gd;
    exp_t e;
    if (reset) begin
      chk("rst_inst_addr_ok", 64'(bus.inst_addr_ok), 64'd0);
      chk("rst_data_addr_ok", 64'(bus.data_addr_ok), 64'd0);
      chk("rst_sram_en",      64'(bus.sram_en),      64'd0);
      chk("rst_sram_we",      64'(bus.sram_we),      64'd0);
      chk("rst_inst_data_ok", 64'(bus.inst_data_ok), 64'd0);
      chk("rst_data_data_ok", 64'(bus.data_data_ok), 64'd0);
      chk("rst_inst_rdata",   64'(bus.inst_rdata),   64'd0);
      chk("rst_data_rdata",   64'(bus.data_rdata),   64'd0);
      return;
    end
    gi = ip.v && (!dp.v || last_data);
    gd = dp.v && (!ip.v || !last_data);
    chk("inst_addr_ok", 64'(bus.inst_addr_ok), 64'(gi));
    chk("data_addr_ok", 64'(bus.data_addr_ok), 64'(gd));
    chk("sram_en", 64'(bus.sram_en), 64'(ip.v | dp.v));
    chk("sram_we", 64'(bus.sram_we), (gd && dp.wr) ? 64'(dp.strb) : 64'd0);
    if (gi) chk("sram_addr_inst", 64'(bus.sram_addr), 64'(ip.addr));
    if (gd) chk("sram_addr_data", 64'(bus.sram_addr), 64'(dp.addr));
    if (gd && dp.wr) chk("sram_wdata", 64'(bus.sram_wdata), 64'(dp.wdata));
    e.due = cyc + 1;
    if (gi) begin
      e.is_data = 1'b0;
      e.rdata   = ref_mem[ip.addr[5:2]];
      sb.push_back(e);
      last_data = 1'b0;
      ip.v      = 1'b0;
    end else if (gd) begin
      e.is_data = 1'b1;
      if (dp.wr) begin
        e.rdata = '0;
        for (int b = 0; b < SW; b++)
          if (dp.strb[b]) ref_mem[dp.addr[5:2]][8*b +: 8] = dp.wdata[8*b +: 8];
      end else begin
        e.rdata = ref_mem[dp.addr[5:2]];
      end
      sb.push_back(e);
      last_data = 1'b1;
      dp.v      = 1'b0;
    end
  endtask

  // Monitor: any response due or presented this cycle is compared against the queue head.
  always @(negedge clk) begin
    bit   has;
    exp_t e;
    has = (sb.size() > 0) && (sb[0].due == cyc);
    e   = '{due: 0, is_data: 1'b0, rdata: '0};
    if (has) e = sb.pop_front();
    if (has || bus.inst_data_ok || bus.data_data_ok) begin
      chk("inst_data_ok", 64'(bus.inst_data_ok), 64'(has && !e.is_data));
      chk("data_data_ok", 64'(bus.data_data_ok), 64'(has && e.is_data));
      chk("inst_rdata", 64'(bus.inst_rdata), (has && !e.is_data) ? 64'(e.rdata) : 64'd0);
      chk("data_rdata", 64'(bus.data_rdata), (has && e.is_data) ? 64'(e.rdata) : 64'd0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply();
    @(negedge clk);
    evaluate();
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        reset = 1'b1;
        sb.delete();
        last_data = 1'b1;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_word(i);
      end
      apply();
      @(negedge clk);
      evaluate();
    end
  endtask

  initial begin
    ip = '{v: 1'b1, addr: 32'h40};
    dp = '{v: 1'b1, wr: 1'b1, strb: 4'hF, addr: 32'h44, wdata: 32'hDEAD_BEEF};
    last_data = 1'b1;
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_word(i);
    apply();

    // Both requesting during reset: nothing may be granted or enabled.
    do_reset(3);
    ip.v = 1'b0;
    dp.v = 1'b0;

    // Instruction-only fetch.
    ip = '{v: 1'b1, addr: 32'h1C00_0000};
    cycle();
    cycle();
    chk("fetch_rdata_const", 64'(bus.inst_rdata), 64'h0280_0C0C);

    // Partial data write, then read it back.
    dp = '{v: 1'b1, wr: 1'b1, strb: 4'h3, addr: 32'h10, wdata: 32'hAABB_CCDD};
    cycle();
    dp = '{v: 1'b1, wr: 1'b0, strb: 4'h0, addr: 32'h10, wdata: 32'h0};
    cycle();
    cycle();
    chk("merge_rdata_const", 64'(bus.data_rdata), 64'h1004_CCDD);

    // Continuous contention for six cycles: strict alternation starting with INST.
    for (int i = 0; i < 6; i++) begin
      ip = '{v: 1'b1, addr: 32'(i * 4)};
      dp = '{v: 1'b1, wr: 1'b0, strb: 4'h0, addr: 32'(32 + i * 4), wdata: 32'h0};
      cycle();
      chk("contend_inst_first", 64'(bus.inst_addr_ok), 64'((i % 2) == 0));
    end
    ip.v = 1'b0;
    dp.v = 1'b0;
    cycle();

    // Back-to-back instruction reads.
    for (int i = 0; i < 3; i++) begin
      ip = '{v: 1'b1, addr: 32'(i * 4)};
      cycle();
    end
    ip.v = 1'b0;
    cycle();

    // Idle cycles, then a conflict: winner is the one not granted most recently (INST last -> DATA).
    repeat (3) cycle();
    ip = '{v: 1'b1, addr: 32'h8};
    dp = '{v: 1'b1, wr: 1'b0, strb: 4'h0, addr: 32'hC, wdata: 32'h0};
    cycle();
    chk("idle_keeps_last", 64'(bus.data_addr_ok), 64'd1);
    cycle();
    cycle();

    // Reset right after a data read grant: the response is dropped, INST wins next conflict.
    dp = '{v: 1'b1, wr: 1'b0, strb: 4'h0, addr: 32'h20, wdata: 32'h0};
    cycle();
    do_reset(2);
    ip = '{v: 1'b1, addr: 32'h4};
    dp = '{v: 1'b1, wr: 1'b0, strb: 4'h0, addr: 32'h24, wdata: 32'h0};
    cycle();
    chk("post_reset_inst_wins", 64'(bus.inst_addr_ok), 64'd1);
    cycle();
    cycle();

    // Random traffic; requests are held until accepted.
    repeat (600) begin
      if (!ip.v && $urandom_range(0, 3) != 0) begin
        ip.v    = 1'b1;
        ip.addr = $urandom & ~32'h3;
      end
      if (!dp.v && $urandom_range(0, 3) != 0) begin
        dp.v     = 1'b1;
        dp.wr    = 1'($urandom_range(0, 1));
        dp.strb  = SW'($urandom);
        dp.addr  = $urandom & ~32'h3;
        dp.wdata = $urandom;
      end
      cycle();
    end

    ip.v = 1'b0;
    dp.v = 1'b0;
    cycle();
    cycle();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
